// File: rtl/id_ex_hazard_stage_pkg.sv
// rtl/id_ex_hazard_stage_pkg.sv - shared constants, field helpers and EX register type for the ID/EX stage
//
// Contents:
//   NOP_WORD                 canonical NOP (addi x0,x0,0) loaded into ir_e on reset or bubble
//   CTRL_*                   bit positions in the 32-bit control word
//   RS1_LSB/RS2_LSB/RD_LSB   register-field slice positions in the instruction word
//   ex_reg_t                 packed image of the ID/EX pipeline register
//   ex_bubble()              EX register contents for an inserted bubble
package id_ex_hazard_stage_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam int CTRL_RF_WE   = 7;
    localparam int CTRL_WB_MEM  = 2;
    localparam int CTRL_USE_RS1 = 9;
    localparam int CTRL_USE_RS2 = 8;

    localparam int REG_W   = 5;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB  = 7;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] ctrl;
    } ex_reg_t;

    function automatic ex_reg_t ex_bubble(input logic [31:0] nop);
        ex_reg_t r;
        r       = '0;
        r.ir    = nop;
        return r;
    endfunction

endpackage

// File: rtl/id_ex_hazard_stage_load_use_detect.sv
// rtl/id_ex_hazard_stage_load_use_detect.sv - combinational load-use hazard detector
//
// Ports:
//   ir_d, ctrl_d, valid_d   instruction in ID
//   ir_e, ctrl_e, valid_e   instruction in EX
//   lu                      EX holds a load whose rd (non-x0) is read by the ID instruction
module load_use_detect
    import id_ex_hazard_stage_pkg::*;
(
    input  logic [31:0] ir_d,
    input  logic [31:0] ctrl_d,
    input  logic        valid_d,
    input  logic [31:0] ir_e,
    input  logic [31:0] ctrl_e,
    input  logic        valid_e,
    output logic        lu
);

    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd_e;
    logic             load_in_ex;
    logic             rs1_hit;
    logic             rs2_hit;

    assign rs1  = ir_d[RS1_LSB +: REG_W];
    assign rs2  = ir_d[RS2_LSB +: REG_W];
    assign rd_e = ir_e[RD_LSB +: REG_W];

    // A bubble (valid_e=0) or a load into x0 can never create a dependency.
    assign load_in_ex = valid_e & ctrl_e[CTRL_RF_WE] & ctrl_e[CTRL_WB_MEM] & (rd_e != '0);

    assign rs1_hit = ctrl_d[CTRL_USE_RS1] & (rs1 == rd_e);
    assign rs2_hit = ctrl_d[CTRL_USE_RS2] & (rs2 == rd_e);

    assign lu = load_in_ex & valid_d & (rs1_hit | rs2_hit);

    // Only a few fields of each word matter here; fold the rest into one sink.
    logic unused_bits;
    assign unused_bits = ^{ir_d[31:25], ir_d[14:0], ir_e[31:12], ir_e[6:0],
                           ctrl_d[31:10], ctrl_d[7:0],
                           ctrl_e[31:8], ctrl_e[6:3], ctrl_e[1:0]};

endmodule

// File: rtl/id_ex_hazard_stage.sv
// rtl/id_ex_hazard_stage.sv - ID/EX pipeline register with load-use stall, branch flush and debug hold
//
// Optional feature macro: HAZARD_STAT_EN (stall/flush event counters; tied to 0 when undefined)
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   hold                           debug freeze: all state holds, IF/ID stalled
//   valid_d/pc_d/ir_d/a_d/b_d/imm_d/ctrl_d   ID-stage instruction and forwarded operands
//   branch_taken_e                 EX redirect; kills the ID instruction
//   valid_e/pc_e/ir_e/a_e/b_e/imm_e/ctrl_e   registered EX-stage copies
//   stall_f                        hold PC and IF/ID register (combinational)
//   flush_d                        invalidate IF/ID register (combinational)
//   stall_cnt, flush_cnt           saturating load-use stall / flush counters
module id_ex_hazard_stage
    import id_ex_hazard_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSN = NOP_WORD
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        hold,
    input  logic        valid_d,
    input  logic [31:0] pc_d,
    input  logic [31:0] ir_d,
    input  logic [31:0] a_d,
    input  logic [31:0] b_d,
    input  logic [31:0] imm_d,
    input  logic [31:0] ctrl_d,
    input  logic        branch_taken_e,
    output logic        valid_e,
    output logic [31:0] pc_e,
    output logic [31:0] ir_e,
    output logic [31:0] a_e,
    output logic [31:0] b_e,
    output logic [31:0] imm_e,
    output logic [31:0] ctrl_e,
    output logic        stall_f,
    output logic        flush_d,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    ex_reg_t ex_q;
    ex_reg_t ex_d;
    logic    lu;
    logic    stall_raw;
    logic    flush_raw;

    load_use_detect u_load_use_detect (
        .ir_d    (ir_d),
        .ctrl_d  (ctrl_d),
        .valid_d (valid_d),
        .ir_e    (ex_q.ir),
        .ctrl_e  (ex_q.ctrl),
        .valid_e (ex_q.valid),
        .lu      (lu)
    );

    // Priority: hold > branch flush > load-use stall > normal capture.
    // A taken branch kills the ID instruction, so its load-use hazard is moot.
    always_comb begin
        ex_d      = ex_q;
        stall_raw = 1'b0;
        flush_raw = 1'b0;
        if (hold) begin
            stall_raw = 1'b1;
        end else if (branch_taken_e) begin
            ex_d      = ex_bubble(NOP_INSN);
            flush_raw = 1'b1;
        end else if (lu) begin
            ex_d      = ex_bubble(NOP_INSN);
            stall_raw = 1'b1;
        end else begin
            ex_d.valid = valid_d;
            ex_d.pc    = pc_d;
            ex_d.ir    = ir_d;
            ex_d.a     = a_d;
            ex_d.b     = b_d;
            ex_d.imm   = imm_d;
            ex_d.ctrl  = ctrl_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_q <= ex_bubble(NOP_INSN);
        end else begin
            ex_q <= ex_d;
        end
    end

    // Strobes are forced low while reset is asserted, even if hold/branch are driven.
    assign stall_f = stall_raw & rstn;
    assign flush_d = flush_raw & rstn;

    assign valid_e = ex_q.valid;
    assign pc_e    = ex_q.pc;
    assign ir_e    = ex_q.ir;
    assign a_e     = ex_q.a;
    assign b_e     = ex_q.b;
    assign imm_e   = ex_q.imm;
    assign ctrl_e  = ex_q.ctrl;

`ifdef HAZARD_STAT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] flush_cnt_q;
    logic [31:0] flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!hold && !branch_taken_e && lu && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (!hold && branch_taken_e && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// tb/tb_id_ex_hazard_stage.sv - directed self-checking bench for id_ex_hazard_stage
module tb_id_ex_hazard_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] LW5    = 32'h0000_A283; // lw x5,0(x1)
    localparam logic [31:0] LW0    = 32'h0000_A003; // lw x0,0(x1)
    localparam logic [31:0] LW7    = 32'h0000_A383; // lw x7,0(x1)
    localparam logic [31:0] ADD6   = 32'h0022_8333; // add x6,x5,x2
    localparam logic [31:0] ADD600 = 32'h0000_0333; // add x6,x0,x0
    localparam logic [31:0] RS2_5  = 32'h0051_0333; // rs1=x2, rs2=x5, rd=x6
    localparam logic [31:0] ADD8   = 32'h0073_8433; // add x8,x7,x7
    localparam logic [31:0] C_LD   = 32'h0000_0284; // rf_we, wb_mem, use_rs1
    localparam logic [31:0] C_ALU  = 32'h0000_0380; // rf_we, use_rs1, use_rs2
    localparam logic [31:0] C_RS1  = 32'h0000_0280; // rf_we, use_rs1 only

`ifdef HAZARD_STAT_EN
    localparam int STAT = 1;
`else
    localparam int STAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        hold = 1'b0;
    logic        valid_d = 1'b0;
    logic [31:0] pc_d = '0, ir_d = '0, a_d = '0, b_d = '0, imm_d = '0, ctrl_d = '0;
    logic        branch_taken_e = 1'b0;
    logic        valid_e, stall_f, flush_d;
    logic [31:0] pc_e, ir_e, a_e, b_e, imm_e, ctrl_e, stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_hazard_stage dut (
        .clk(clk), .rstn(rstn), .hold(hold),
        .valid_d(valid_d), .pc_d(pc_d), .ir_d(ir_d), .a_d(a_d), .b_d(b_d),
        .imm_d(imm_d), .ctrl_d(ctrl_d), .branch_taken_e(branch_taken_e),
        .valid_e(valid_e), .pc_e(pc_e), .ir_e(ir_e), .a_e(a_e), .b_e(b_e),
        .imm_e(imm_e), .ctrl_e(ctrl_e), .stall_f(stall_f), .flush_d(flush_d),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] imm, input logic [31:0] ctrl);
        valid_d = v; pc_d = pc; ir_d = ir; a_d = a; b_d = b; imm_d = imm; ctrl_d = ctrl;
    endtask

    task automatic do_reset();
        hold = 1'b0;
        branch_taken_e = 1'b0;
        drive_id(1'b0, '0, NOP, '0, '0, '0, '0);
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        drive_id(1'b1, 32'h100, ADD6, 32'd11, 32'd22, 32'd33, C_ALU);
        tick();
        total++; if (valid_e !== 1'b1) begin bad++; $display("FAIL rst_pre_valid got=%0b exp=1", valid_e); end
        drive_id(1'b1, 32'h104, LW5, 32'd1, 32'd2, 32'd3, C_LD);
        #2;
        rstn = 1'b0;
        hold = 1'b1;
        branch_taken_e = 1'b1;
        #1;
        total++; if (valid_e !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", valid_e); end
        total++; if (ir_e !== NOP) begin bad++; $display("FAIL rst_ir got=%h exp=%h", ir_e, NOP); end
        total++; if (ctrl_e !== 32'h0) begin bad++; $display("FAIL rst_ctrl got=%h exp=0", ctrl_e); end
        total++; if (pc_e !== 32'h0 || a_e !== 32'h0 || b_e !== 32'h0 || imm_e !== 32'h0) begin
            bad++; $display("FAIL rst_data got pc=%h a=%h b=%h imm=%h exp all 0", pc_e, a_e, b_e, imm_e); end
        total++; if (stall_f !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b exp=0", stall_f); end
        total++; if (flush_d !== 1'b0) begin bad++; $display("FAIL rst_flush got=%0b exp=0", flush_d); end
        total++; if (stall_cnt !== 32'h0 || flush_cnt !== 32'h0) begin
            bad++; $display("FAIL rst_cnt got=%h/%h exp=0/0", stall_cnt, flush_cnt); end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        hold = 1'b0;
        branch_taken_e = 1'b0;
        drive_id(1'b1, 32'h200, LW7, 32'd5, 32'd6, 32'd7, C_LD);
        tick();
        total++; if (valid_e !== 1'b1 || ir_e !== LW7 || pc_e !== 32'h200 || imm_e !== 32'd7) begin
            bad++; $display("FAIL rst_release got v=%0b ir=%h pc=%h imm=%h exp v=1 ir=%h pc=200 imm=7",
                            valid_e, ir_e, pc_e, imm_e, LW7); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive_id(1'b1, 32'h10, LW5, 32'h1, 32'h0, 32'h0, C_LD);
        tick();
        total++; if (ir_e !== LW5) begin bad++; $display("FAIL lu_load_in_ex got=%h exp=%h", ir_e, LW5); end
        drive_id(1'b1, 32'h14, ADD6, 32'hAAAA, 32'hBBBB, 32'h0, C_ALU);
        #1;
        total++; if (stall_f !== 1'b1 || flush_d !== 1'b0) begin
            bad++; $display("FAIL lu_stall got stall=%0b flush=%0b exp 1/0", stall_f, flush_d); end
        tick();
        total++; if (valid_e !== 1'b0 || ir_e !== NOP || ctrl_e !== 32'h0) begin
            bad++; $display("FAIL lu_bubble got v=%0b ir=%h ctrl=%h exp 0/%h/0", valid_e, ir_e, ctrl_e, NOP); end
        total++; if (stall_f !== 1'b0) begin bad++; $display("FAIL lu_stall_drop got=%0b exp=0", stall_f); end
        tick();
        total++; if (valid_e !== 1'b1 || ir_e !== ADD6 || a_e !== 32'hAAAA || b_e !== 32'hBBBB || pc_e !== 32'h14) begin
            bad++; $display("FAIL lu_add_enters got v=%0b ir=%h a=%h b=%h pc=%h exp 1/%h/aaaa/bbbb/14",
                            valid_e, ir_e, a_e, b_e, pc_e, ADD6); end
        total++; if (stall_cnt !== 32'(STAT)) begin
            bad++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt, STAT); end
    endtask

    task automatic test_no_false_stall();
        do_reset();
        drive_id(1'b1, 32'h20, LW0, 32'h0, 32'h0, 32'h0, C_LD);
        tick();
        drive_id(1'b1, 32'h24, ADD600, 32'h0, 32'h0, 32'h0, C_ALU);
        #1;
        total++; if (stall_f !== 1'b0) begin bad++; $display("FAIL nfs_rd_x0 got=%0b exp=0", stall_f); end
        drive_id(1'b1, 32'h28, LW5, 32'h0, 32'h0, 32'h0, C_LD);
        tick();
        drive_id(1'b1, 32'h2C, RS2_5, 32'h7, 32'h8, 32'h0, C_RS1);
        #1;
        total++; if (stall_f !== 1'b0) begin bad++; $display("FAIL nfs_rs2_unused got=%0b exp=0", stall_f); end
        tick();
        total++; if (valid_e !== 1'b1 || ir_e !== RS2_5) begin
            bad++; $display("FAIL nfs_capture got v=%0b ir=%h exp 1/%h", valid_e, ir_e, RS2_5); end
        total++; if (stall_cnt !== 32'h0) begin bad++; $display("FAIL nfs_stall_cnt got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        drive_id(1'b1, 32'h30, LW5, 32'h0, 32'h0, 32'h0, C_LD);
        tick();
        drive_id(1'b1, 32'h34, ADD6, 32'h5, 32'h6, 32'h7, C_ALU);
        branch_taken_e = 1'b1;
        #1;
        total++; if (flush_d !== 1'b1 || stall_f !== 1'b0) begin
            bad++; $display("FAIL fl_strobes got flush=%0b stall=%0b exp 1/0", flush_d, stall_f); end
        tick();
        branch_taken_e = 1'b0;
        total++; if (valid_e !== 1'b0 || ir_e !== NOP || pc_e !== 32'h0 || a_e !== 32'h0 || ctrl_e !== 32'h0) begin
            bad++; $display("FAIL fl_bubble got v=%0b ir=%h pc=%h a=%h ctrl=%h exp 0/%h/0/0/0",
                            valid_e, ir_e, pc_e, a_e, ctrl_e, NOP); end
        total++; if (flush_cnt !== 32'(STAT) || stall_cnt !== 32'h0) begin
            bad++; $display("FAIL fl_cnt got flush=%0d stall=%0d exp %0d/0", flush_cnt, stall_cnt, STAT); end
    endtask

    task automatic test_hold();
        do_reset();
        drive_id(1'b1, 32'h40, ADD6, 32'h1, 32'h2, 32'h3, C_ALU);
        tick();
        hold = 1'b1;
        branch_taken_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_id(1'b1, 32'h50 + 32'(i * 4), LW7, 32'(100 + i), 32'(200 + i), 32'(i), C_LD);
            #1;
            total++; if (stall_f !== 1'b1 || flush_d !== 1'b0) begin
                bad++; $display("FAIL hold_strobes cyc=%0d got stall=%0b flush=%0b exp 1/0", i, stall_f, flush_d); end
            tick();
            total++; if (valid_e !== 1'b1 || pc_e !== 32'h40 || ir_e !== ADD6 || a_e !== 32'h1 ||
                         b_e !== 32'h2 || imm_e !== 32'h3 || ctrl_e !== C_ALU) begin
                bad++; $display("FAIL hold_frozen cyc=%0d got pc=%h ir=%h a=%h exp 40/%h/1", i, pc_e, ir_e, a_e, ADD6); end
        end
        total++; if (flush_cnt !== 32'h0 || stall_cnt !== 32'h0) begin
            bad++; $display("FAIL hold_cnt got flush=%0d stall=%0d exp 0/0", flush_cnt, stall_cnt); end
        hold = 1'b0;
        branch_taken_e = 1'b0;
        drive_id(1'b1, 32'h60, LW5, 32'h9, 32'h0, 32'h0, C_LD);
        tick();
        total++; if (valid_e !== 1'b1 || pc_e !== 32'h60 || ir_e !== LW5 || a_e !== 32'h9) begin
            bad++; $display("FAIL hold_release got pc=%h ir=%h a=%h exp 60/%h/9", pc_e, ir_e, a_e, LW5); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prog [4];
        logic [31:0] ctl  [4];
        logic [31:0] seen [$];
        int idx;
        int stalls;
        logic stall_now;
        prog[0] = LW5;  ctl[0] = C_LD;
        prog[1] = ADD6; ctl[1] = C_ALU;
        prog[2] = LW7;  ctl[2] = C_LD;
        prog[3] = ADD8; ctl[3] = C_ALU;
        idx = 0;
        stalls = 0;
        do_reset();
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (idx < 4) drive_id(1'b1, 32'(idx * 4), prog[idx], 32'(idx), 32'h0, 32'h0, ctl[idx]);
            else         drive_id(1'b0, 32'h0, NOP, 32'h0, 32'h0, 32'h0, 32'h0);
            #1;
            stall_now = stall_f;
            if (stall_now) stalls++;
            tick();
            if (!stall_now && idx < 4) idx++;
            if (valid_e) seen.push_back(ir_e);
        end
        total++; if (stalls !== 2) begin bad++; $display("FAIL b2b_stalls got=%0d exp=2", stalls); end
        total++; if (seen.size() !== 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", seen.size()); end
        for (int i = 0; i < 4; i++) begin
            total++; if (i >= seen.size() || seen[i] !== prog[i]) begin
                bad++; $display("FAIL b2b_order idx=%0d got=%h exp=%h", i,
                                (i < seen.size()) ? seen[i] : 32'hx, prog[i]); end
        end
        total++; if (stall_cnt !== 32'(2 * STAT)) begin
            bad++; $display("FAIL b2b_stall_cnt got=%0d exp=%0d", stall_cnt, 2 * STAT); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_flush();
        test_hold();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32I core, plus load-use stall and branch-flush control.
- Captures the forwarded ID operands, PC, IR, immediate and control word into EX. Inserts bubbles and drives the IF/ID stall and flush strobes.
- Honours the debug-unit `hold` freeze used for single-stepping.

Parameters:
- NOP_INSN, 32'h0000_0013, instruction word loaded into `ir_e` on reset or bubble.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- hold  in  1  debug freeze; all state holds
- valid_d  in  1  ID instruction valid
- pc_d  in  32  ID PC
- ir_d  in  32  ID instruction
- a_d  in  32  forwarded rs1 operand
- b_d  in  32  forwarded rs2 operand
- imm_d  in  32  ID immediate
- ctrl_d  in  32  ID control word
- branch_taken_e  in  1  EX redirect (taken branch or jump)
- valid_e  out  1  EX instruction valid
- pc_e  out  32  registered PC
- ir_e  out  32  registered instruction
- a_e  out  32  registered rs1 operand
- b_e  out  32  registered rs2 operand
- imm_e  out  32  registered immediate
- ctrl_e  out  32  registered control word
- stall_f  out  1  hold PC and IF/ID register
- flush_d  out  1  invalidate IF/ID register
- stall_cnt  out  32  load-use stall count (optional feature)
- flush_cnt  out  32  flush count (optional feature)

Behaviour:
- Control word bits:
  - ctrl[7] = register-file write enable.
  - ctrl[2] = writeback from memory (load).
  - ctrl[9] = instruction reads rs1.
  - ctrl[8] = instruction reads rs2.
- Field extraction: rs1 = ir_d[19:15], rs2 = ir_d[24:20], rd_e = ir_e[11:7].
- Load-use hazard `lu` (combinational) is asserted when all of the following hold:
  - valid_e & ctrl_e[7] & ctrl_e[2];
  - rd_e != 0;
  - valid_d;
  - (ctrl_d[9] & rs1 == rd_e) | (ctrl_d[8] & rs2 == rd_e).
- Per-cycle priority: hold > branch_taken_e > lu > normal.
  - hold=1: all registers keep their value; stall_f=1; flush_d=0; counters do not change.
  - branch_taken_e=1:
    - EX register loads a bubble: valid_e=0, ctrl_e=0, ir_e=NOP_INSN, pc_e/a_e/b_e/imm_e=0.
    - flush_d=1; stall_f=0.
    - lu is ignored because the ID instruction is being killed.
  - lu=1: EX loads the bubble; stall_f=1; flush_d=0. The next cycle sees a bubble in EX, so lu drops and ID advances. Stall latency is exactly 1 cycle per load-use pair.
  - Normal: EX register loads the *_d inputs, with valid_e=valid_d. stall_f=0, flush_d=0.
- stall_f and flush_d are combinational from the current inputs and EX state, with zero-cycle latency to the IF/ID register.
- Capture latency: ID inputs appear on *_e one clock after the capturing edge.
- Reset (asynchronous, rstn=0):
  - Applies immediately mid-operation.
  - valid_e=0, ir_e=NOP_INSN, all other registered outputs 0, counters 0.
  - stall_f and flush_d are 0 while in reset.
- rd_e==x0 never stalls, and a bubble in EX never stalls.

Optional Feature:
- Macro: HAZARD_STAT_EN.
- Defined:
  - stall_cnt increments on each cycle with hold=0, branch_taken_e=0 and lu=1.
  - flush_cnt increments on each cycle with hold=0 and branch_taken_e=1.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
  - Both are readable by the serial debug unit.
- Undefined: no counter registers; stall_cnt and flush_cnt are tied to 0, keeping the port list stable.

Decomposition:
- Shared package holds:
  - NOP constant 32'h0000_0013;
  - control bit indices CTRL_RF_WE=7, CTRL_WB_MEM=2, CTRL_USE_RS1=9, CTRL_USE_RS2=8;
  - register-field slice positions.
- One natural combinational sub-module, load_use_detect: inputs ir_d, ctrl_d, valid_d, ir_e, ctrl_e, valid_e; output lu.
- The pipeline register, priority logic and counters stay in the top.

Test Plan:
- Reset: hold rstn=0 mid-stream → valid_e=0, ir_e=0x00000013, ctrl_e=0, stall_f=0, counters 0; release → next ID instruction captured.
- Load-use: EX holds `lw x5,0(x1)` (ctrl_e bits 7 and 2 set, rd=5); ID holds `add x6,x5,x2` (ctrl_d bit 9 set) → stall_f=1 for exactly one cycle, EX bubble (valid_e=0), then the add enters EX with a_e=a_d; stall_cnt=1.
- No false stall:
  - same load with rd=x0 → stall_f=0;
  - load rd=5 with ID reading rs2=5 but ctrl_d bit 8 clear → stall_f=0.
- Flush beats load-use: branch_taken_e=1 while the load-use condition holds → flush_d=1, stall_f=0, EX bubble; flush_cnt=1, stall_cnt unchanged.
- Debug hold: hold=1 for 3 cycles with changing *_d inputs and branch_taken_e=1 → *_e unchanged, stall_f=1, flush_d=0, counters unchanged; release → normal capture.
- Back-to-back: load then dependent instruction, followed immediately by a second load-use pair → two separate single-cycle stalls, stall_cnt=2, every instruction reaches EX exactly once.
